timer_apb_sequencer: RTL and testbench
======================================

// Module: timer_apb_sequencer
// PURPOSE
//  APB master that programs and services the 64-bit timer IP over its APB slave port (tim_p*).
//  Arms a compare at current count + period, waits for tim_int, clears TISR, and in periodic mode re-arms at previous compare + period.
//  Sits between a local control interface (start/stop/period) and the timer; it is the timer's only APB master.
// PARAMETERS
//  PREADY_TMO  16  max ACCESS-phase cycles waiting for tim_pready before abort (>=2)
//  CNT_W       16  width of expire_cnt
// PORTS
//  sys_clk      in   1   clock
//  sys_rst_n    in   1   asynchronous active-low reset
//  start        in   1   pulse: arm timer; sampled only in IDLE
//  stop         in   1   pulse: disarm; latched, honoured between transfers
//  periodic     in   1   sampled at accepted start: 1=auto re-arm, 0=one-shot
//  period       in   64  sampled at accepted start; compare increment in timer ticks
//  div_en       in   1   sampled at accepted start -> TCR[1]
//  div_val      in   4   sampled at accepted start -> TCR[11:8]; values >8 clamp to 8
//  tim_psel     out  1   APB select
//  tim_penable  out  1   APB enable
//  tim_pwrite   out  1   APB direction
//  tim_paddr    out  12  APB address
//  tim_pwdata   out  32  APB write data
//  tim_prdata   in   32  APB read data, valid when tim_pready=1
//  tim_pready   in   1   APB ready
//  tim_int      in   1   timer interrupt (level)
//  busy         out  1   1 in any state except IDLE/ERR
//  done         out  1   1-cycle pulse per serviced expiry, asserted in the cycle TISR clear completes
//  expire_cnt   out  CNT_W  serviced expiries since last accepted start; saturates at all-ones
//  cfg_err      out  1   1-cycle pulse: start rejected (period==0)
//  bus_err      out  1   sticky: APB timeout; cleared by next accepted start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal cmp/period regs 0; int_pend 0.
//  APB transfer: SETUP 1 cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1) until tim_pready=1; min 2 cycles.
//   Addr/data/direction stay stable across SETUP+ACCESS; psel drops the cycle after completion; no back-to-back without SETUP.
//   Read data captured on the cycle tim_pready=1.
//  Timeout: ACCESS reaching PREADY_TMO cycles -> psel/penable=0, bus_err=1, state ERR. ERR exits only via start.
//  Register addrs: TCR 0x000, TDR0 0x004, TDR1 0x008, TCMP0 0x00C, TCMP1 0x010, TIER 0x014, TISR 0x018.
//  FSM, each state one APB transfer unless noted:
//   IDLE   : start & period!=0 -> RD_LO (sample cfg, clear expire_cnt/bus_err); start & period==0 -> cfg_err pulse, stay.
//   RD_LO  : read TDR0; RD_HI: read TDR1; cmp <= {TDR1,TDR0} + period (mod 2^64). Timer is disabled here, so the two halves are coherent.
//   WR_C0  : TCMP0=cmp[31:0]; WR_C1: TCMP1=cmp[63:32]; -> WR_IE on first arm, else WAIT.
//   WR_IE  : TIER=1; WR_EN: TCR={20'b0,div_val,6'b0,div_en,1'b1}; -> WAIT.
//   WAIT   : no bus activity; int_pend -> CLR; else stop_pend -> DIS_T.
//   CLR    : TISR=1 (write-1-clear); on completion: done pulse, expire_cnt++, int_pend<=0;
//            stop_pend or !periodic -> DIS_T; else cmp <= cmp+period -> WR_C0.
//   DIS_T  : TCR={20'b0,div_val,6'b0,div_en,1'b0}; DIS_I: TIER=0; -> IDLE; stop_pend<=0.
//  Interrupt detect: rising edge of registered tim_int sets int_pend in any state. Edge during a transfer is held, not lost.
//  stop: sets stop_pend in any busy state; never aborts an in-flight transfer. In IDLE/ERR it is ignored.
//  Simultaneous int_pend and stop_pend in WAIT: service CLR first (done pulses), then DIS_T, no re-arm.
//  start while busy: ignored. Wrap: 64-bit adds wrap silently; period>=2^63 is legal.
//  Reset mid-transfer: psel/penable drop asynchronously; no completion is reported.
// STRUCTURE
//  Package timer_seq_pkg: register address localparams, TCR field positions, FSM state enum.
//  One sub-module apb_xfer_master: single-transfer engine (req/addr/wdata/write in; ack/rdata/timeout out; owns PREADY_TMO counter).
//  The top holds the FSM, cmp/period regs, pend flags and expire_cnt.
// TESTING
//  1 Reset, TDR=0x0, start period=100 periodic=0 div_en=0 -> writes TCMP0=100, TCMP1=0, TIER=1, TCR=0x001. On tim_int edge: TISR=1, done x1, then TCR=0x000, TIER=0.
//  2 TDR={0x0,0xFFFF_FFF0}, period=0x20 -> TCMP0=0x10, TCMP1=0x1 (carry). TDR=all-ones, period=2 -> cmp=1 (64-bit wrap).
//  3 periodic=1 period=50 from 0, three tim_int edges -> TCMP0 writes 50,100,150,200; expire_cnt=3; no re-write of TIER/TCR.
//  4 stop during WR_C0 ACCESS with pready delayed 3 cycles -> transfer completes, WR_C1 and WR_IE/WR_EN still run, then DIS_T, DIS_I, IDLE; busy=0.
//  5 tim_int edge and stop same cycle in WAIT -> TISR clear, done=1, then disable, no TCMP write.
//  6 tim_pready held 0 -> psel drops after 16 ACCESS cycles, bus_err=1, ERR. start period=0 -> cfg_err pulse. start period=10 -> bus_err cleared, sequence restarts.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer APB sequencer: register map, TCR layout,
// FSM state encodings and the TCR word builder.
package timer_seq_pkg;

    localparam logic [11:0] ADDR_TCR   = 12'h000;
    localparam logic [11:0] ADDR_TDR0  = 12'h004;
    localparam logic [11:0] ADDR_TDR1  = 12'h008;
    localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
    localparam logic [11:0] ADDR_TCMP1 = 12'h010;
    localparam logic [11:0] ADDR_TIER  = 12'h014;
    localparam logic [11:0] ADDR_TISR  = 12'h018;

    localparam int          TCR_EN_BIT     = 0;
    localparam int          TCR_DIV_EN_BIT = 1;
    localparam int          TCR_DIV_LSB    = 8;
    localparam logic [3:0]  DIV_MAX        = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE, ST_RD_LO, ST_RD_HI, ST_WR_C0, ST_WR_C1, ST_WR_IE,
        ST_WR_EN, ST_WAIT, ST_CLR, ST_DIS_T, ST_DIS_I, ST_ERR
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE, PH_SETUP, PH_ACCESS
    } apb_phase_e;

    function automatic logic [31:0] tcr_word(input logic [3:0] div_val,
                                             input logic div_en,
                                             input logic en);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[TCR_DIV_LSB +: 4] = div_val;
        w[TCR_DIV_EN_BIT]   = div_en;
        w[TCR_EN_BIT]       = en;
        return w;
    endfunction

    function automatic logic [3:0] clamp_div(input logic [3:0] div_val);
        return (div_val > DIV_MAX) ? DIV_MAX : div_val;
    endfunction

endpackage

// File: rtl/apb_xfer_master.sv
// Single-transfer APB master: SETUP then ACCESS until pready, or abort after
// PREADY_TMO ACCESS cycles. ack/timeout are one-cycle pulses after the end.
module apb_xfer_master
    import timer_seq_pkg::*;
#(
    parameter int PREADY_TMO = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    input  logic        write,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [11:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);

    localparam int TW = $clog2(PREADY_TMO + 1);

    apb_phase_e      phase_r, phase_nx;
    logic [TW-1:0]   wait_cnt_r;
    logic            done_s, tmo_s;
    logic            psel_r, penable_r, pwrite_r, ack_r, timeout_r;
    logic [11:0]     paddr_r;
    logic [31:0]     pwdata_r, rdata_r;

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_r <= PH_IDLE;
        else        phase_r <= phase_nx;
    end

    // Phase sequencing, completion and timeout detection
    always_comb begin
        phase_nx = phase_r;
        done_s   = 1'b0;
        tmo_s    = 1'b0;
        case (phase_r)
            PH_IDLE: begin
                if (req) phase_nx = PH_SETUP;
                else     phase_nx = PH_IDLE;
            end
            PH_SETUP: phase_nx = PH_ACCESS;
            PH_ACCESS: begin
                if (pready) begin
                    done_s   = 1'b1;
                    phase_nx = PH_IDLE;
                end else if (wait_cnt_r == TW'(PREADY_TMO - 1)) begin
                    tmo_s    = 1'b1;
                    phase_nx = PH_IDLE;
                end else begin
                    phase_nx = PH_ACCESS;
                end
            end
            default: phase_nx = PH_IDLE;
        endcase
    end

    // Registered bus signals, wait counter and result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= 12'h000;
            pwdata_r   <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
            ack_r      <= 1'b0;
            timeout_r  <= 1'b0;
            wait_cnt_r <= {TW{1'b0}};
        end else begin
            psel_r    <= (phase_nx != PH_IDLE);
            penable_r <= (phase_nx == PH_ACCESS);
            ack_r     <= done_s;
            timeout_r <= tmo_s;
            if (phase_r == PH_IDLE && req) begin
                paddr_r  <= addr;
                pwdata_r <= wdata;
                pwrite_r <= write;
            end
            if (done_s) rdata_r <= prdata;
            if (phase_r == PH_ACCESS && phase_nx == PH_ACCESS) wait_cnt_r <= wait_cnt_r + TW'(1);
            else                                               wait_cnt_r <= {TW{1'b0}};
        end
    end

    assign psel    = psel_r;
    assign penable = penable_r;
    assign pwrite  = pwrite_r;
    assign paddr   = paddr_r;
    assign pwdata  = pwdata_r;
    assign ack     = ack_r;
    assign rdata   = rdata_r;
    assign timeout = timeout_r;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Programs the 64-bit timer over APB: arms a compare at count+period, services
// each interrupt by clearing TISR and, in periodic mode, re-arms at cmp+period.
module timer_apb_sequencer
    import timer_seq_pkg::*;
#(
    parameter int PREADY_TMO = 16,
    parameter int CNT_W      = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [63:0]      period,
    input  logic             div_en,
    input  logic [3:0]       div_val,
    output logic             tim_psel,
    output logic             tim_penable,
    output logic             tim_pwrite,
    output logic [11:0]      tim_paddr,
    output logic [31:0]      tim_pwdata,
    input  logic [31:0]      tim_prdata,
    input  logic             tim_pready,
    input  logic             tim_int,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] expire_cnt,
    output logic             cfg_err,
    output logic             bus_err
);

    seq_state_e       state_r, state_nx, after_s;
    logic [63:0]      cmp_r, period_r;
    logic [31:0]      tdr_lo_r, wdata_s, xfer_rdata_s;
    logic [11:0]      addr_s;
    logic [3:0]       div_val_r;
    logic             periodic_r, div_en_r, first_arm_r, issued_r;
    logic             int_pend_r, stop_pend_r, int_sync_r, int_prev_r;
    logic             req_s, write_s, bus_s, xfer_ack_s, xfer_tmo_s;
    logic             idle_like_s, accept_s, reject_s, int_edge_s;
    logic             done_r, cfg_err_r, bus_err_r, busy_r;
    logic [CNT_W-1:0] expire_cnt_r;

    assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_ERR);
    assign accept_s    = idle_like_s && start && (period != 64'h0);
    assign reject_s    = idle_like_s && start && (period == 64'h0);
    assign int_edge_s  = int_sync_r & ~int_prev_r;

    apb_xfer_master #(.PREADY_TMO(PREADY_TMO)) u_xfer (
        .clk(sys_clk), .rst_n(sys_rst_n),
        .req(req_s), .addr(addr_s), .wdata(wdata_s), .write(write_s),
        .ack(xfer_ack_s), .rdata(xfer_rdata_s), .timeout(xfer_tmo_s),
        .psel(tim_psel), .penable(tim_penable), .pwrite(tim_pwrite),
        .paddr(tim_paddr), .pwdata(tim_pwdata),
        .prdata(tim_prdata), .pready(tim_pready)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_r <= ST_IDLE;
        else            state_r <= state_nx;
    end

    // Next state and the APB transfer requested by each state
    always_comb begin
        state_nx = state_r;
        after_s  = ST_IDLE;
        bus_s    = 1'b1;
        req_s    = 1'b0;
        write_s  = 1'b1;
        addr_s   = ADDR_TCR;
        wdata_s  = 32'h0000_0000;
        case (state_r)
            ST_IDLE, ST_ERR: begin
                bus_s = 1'b0;
                if (accept_s) state_nx = ST_RD_LO;
                else          state_nx = state_r;
            end
            ST_RD_LO: begin write_s = 1'b0; addr_s = ADDR_TDR0; after_s = ST_RD_HI; end
            ST_RD_HI: begin write_s = 1'b0; addr_s = ADDR_TDR1; after_s = ST_WR_C0; end
            ST_WR_C0: begin addr_s = ADDR_TCMP0; wdata_s = cmp_r[31:0];  after_s = ST_WR_C1; end
            ST_WR_C1: begin
                addr_s  = ADDR_TCMP1;
                wdata_s = cmp_r[63:32];
                after_s = first_arm_r ? ST_WR_IE : ST_WAIT;
            end
            ST_WR_IE: begin addr_s = ADDR_TIER; wdata_s = 32'h0000_0001; after_s = ST_WR_EN; end
            ST_WR_EN: begin addr_s = ADDR_TCR; wdata_s = tcr_word(div_val_r, div_en_r, 1'b1); after_s = ST_WAIT; end
            ST_WAIT: begin
                bus_s = 1'b0;
                // A fresh edge counts as pending so a stop in the same cycle still lets CLR go first
                if (int_pend_r || int_edge_s) state_nx = ST_CLR;
                else if (stop_pend_r)         state_nx = ST_DIS_T;
                else                          state_nx = ST_WAIT;
            end
            ST_CLR: begin
                addr_s  = ADDR_TISR;
                wdata_s = 32'h0000_0001;
                after_s = (stop_pend_r || !periodic_r) ? ST_DIS_T : ST_WR_C0;
            end
            ST_DIS_T: begin addr_s = ADDR_TCR; wdata_s = tcr_word(div_val_r, div_en_r, 1'b0); after_s = ST_DIS_I; end
            ST_DIS_I: begin addr_s = ADDR_TIER; wdata_s = 32'h0000_0000; after_s = ST_IDLE; end
            default: begin bus_s = 1'b0; state_nx = ST_IDLE; end
        endcase
        if (bus_s) begin
            req_s = !issued_r;
            if (xfer_tmo_s)      state_nx = ST_ERR;
            else if (xfer_ack_s) state_nx = after_s;
            else                 state_nx = state_r;
        end else begin
            req_s = 1'b0;
        end
    end

    // Handshake bookkeeping and pending-event flags
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            issued_r    <= 1'b0;
            int_sync_r  <= 1'b0;
            int_prev_r  <= 1'b0;
            int_pend_r  <= 1'b0;
            stop_pend_r <= 1'b0;
        end else begin
            int_sync_r <= tim_int;
            int_prev_r <= int_sync_r;
            if (xfer_ack_s || xfer_tmo_s) issued_r <= 1'b0;
            else if (req_s)               issued_r <= 1'b1;
            if (int_edge_s)                              int_pend_r <= 1'b1;
            else if (state_r == ST_CLR && xfer_ack_s)    int_pend_r <= 1'b0;
            else if (accept_s)                           int_pend_r <= 1'b0;
            if (!idle_like_s && stop)                    stop_pend_r <= 1'b1;
            else if (state_r == ST_DIS_I && xfer_ack_s)  stop_pend_r <= 1'b0;
            else if (accept_s)                           stop_pend_r <= 1'b0;
        end
    end

    // Configuration capture, compare arithmetic and registered status outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            period_r     <= 64'h0;
            cmp_r        <= 64'h0;
            tdr_lo_r     <= 32'h0000_0000;
            periodic_r   <= 1'b0;
            div_en_r     <= 1'b0;
            div_val_r    <= 4'h0;
            first_arm_r  <= 1'b0;
            expire_cnt_r <= {CNT_W{1'b0}};
            done_r       <= 1'b0;
            cfg_err_r    <= 1'b0;
            bus_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            done_r    <= (state_r == ST_CLR) && xfer_ack_s;
            cfg_err_r <= reject_s;
            busy_r    <= (state_nx != ST_IDLE) && (state_nx != ST_ERR);
            if (accept_s) begin
                period_r     <= period;
                periodic_r   <= periodic;
                div_en_r     <= div_en;
                div_val_r    <= clamp_div(div_val);
                first_arm_r  <= 1'b1;
                expire_cnt_r <= {CNT_W{1'b0}};
                bus_err_r    <= 1'b0;
            end
            if (xfer_tmo_s) bus_err_r <= 1'b1;
            if (xfer_ack_s) begin
                case (state_r)
                    ST_RD_LO: tdr_lo_r <= xfer_rdata_s;
                    ST_RD_HI: cmp_r    <= {xfer_rdata_s, tdr_lo_r} + period_r;
                    ST_WR_C1: first_arm_r <= 1'b0;
                    ST_CLR: begin
                        if (expire_cnt_r != {CNT_W{1'b1}}) expire_cnt_r <= expire_cnt_r + CNT_W'(1);
                        if (!stop_pend_r && periodic_r)    cmp_r <= cmp_r + period_r;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign expire_cnt = expire_cnt_r;
    assign cfg_err    = cfg_err_r;
    assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Bench for timer_apb_sequencer: APB slave model with random wait states, and a
// reference list of expected register writes derived from the timer programming rules.
module tb_timer_apb_sequencer;

    localparam logic [11:0] A_TCR = 12'h000, A_TDR0 = 12'h004, A_TDR1 = 12'h008;
    localparam logic [11:0] A_TCMP0 = 12'h00C, A_TCMP1 = 12'h010, A_TIER = 12'h014, A_TISR = 12'h018;

    typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;

    logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, periodic = 1'b0, div_en = 1'b0, tim_int = 1'b0;
    logic [63:0] period = 64'h0;
    logic [3:0]  div_val = 4'h0;
    logic [31:0] tim_prdata = 32'h0;
    logic        tim_pready = 1'b0;
    logic        tim_psel, tim_penable, tim_pwrite, busy, done, cfg_err, bus_err;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [15:0] expire_cnt;

    wr_t         got_q[$];
    wr_t         exp_q[$];
    int          errors = 0, checks = 0;
    int          done_cnt = 0, tisr_cnt = 0, access_cycles = 0, wait_left = 0;
    logic [63:0] tdr = 64'h0;
    bit          stall = 1'b0;
    int          fixed_delay = -1;
    logic        cfg_seen;

    timer_apb_sequencer #(.PREADY_TMO(16), .CNT_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .periodic(periodic), .period(period), .div_en(div_en), .div_val(div_val),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_prdata(tim_prdata),
        .tim_pready(tim_pready), .tim_int(tim_int), .busy(busy), .done(done),
        .expire_cnt(expire_cnt), .cfg_err(cfg_err), .bus_err(bus_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic wr_t mk(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    // APB slave: random or fixed wait states, TDR reads, write logging
    always @(negedge sys_clk) begin
        if (tim_psel && !tim_penable) begin
            wait_left     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            access_cycles = 0;
            tim_pready    = 1'b0;
        end else if (tim_psel && tim_penable) begin
            access_cycles++;
            if (!stall && !tim_pready) begin
                if (wait_left == 0) begin
                    tim_pready = 1'b1;
                    if (!tim_pwrite) begin
                        tim_prdata = (tim_paddr == A_TDR1) ? tdr[63:32] :
                                     (tim_paddr == A_TDR0) ? tdr[31:0] : 32'h0;
                    end else begin
                        got_q.push_back(mk(tim_paddr, tim_pwdata));
                        if (tim_paddr == A_TISR && tim_pwdata[0]) tisr_cnt++;
                    end
                end else begin
                    wait_left--;
                end
            end
        end else begin
            tim_pready = 1'b0;
        end
    end

    always @(negedge sys_clk) if (done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_start(input logic [63:0] p, input bit per, input bit de, input logic [3:0] dv);
        @(negedge sys_clk);
        period = p; periodic = per; div_en = de; div_val = dv; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        cfg_seen = cfg_err;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int cyc = 0;
        while (got_q.size() < n && cyc < 400) begin @(negedge sys_clk); cyc++; end
        if (cyc >= 400) chk({tag, " wait_writes timeout"}, 64'(got_q.size()), 64'(n));
    endtask

    task automatic wait_tisr(input int prev, input string tag);
        int cyc = 0;
        while (tisr_cnt <= prev && cyc < 400) begin @(negedge sys_clk); cyc++; end
        if (cyc >= 400) chk({tag, " wait_tisr timeout"}, 64'(tisr_cnt), 64'(prev + 1));
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (busy !== 1'b0 && cyc < 600) begin @(negedge sys_clk); cyc++; end
        if (cyc >= 600) chk({tag, " wait_idle timeout"}, 64'(busy), 64'h0);
    endtask

    // Expected write list from the programming rules, plain 64-bit arithmetic
    task automatic build_exp(input logic [63:0] t, input logic [63:0] p, input bit per, input bit de,
                             input logic [3:0] dv, input int n, input bit stop_last, input bit stop_c0);
        logic [63:0] c;
        logic [31:0] tcr;
        int          dvc;
        exp_q.delete();
        c   = t + p;
        dvc = (dv > 4'd8) ? 8 : int'(dv);
        tcr = (32'(dvc) << 8) | (32'(de) << 1);
        exp_q.push_back(mk(A_TCMP0, c[31:0]));
        exp_q.push_back(mk(A_TCMP1, c[63:32]));
        exp_q.push_back(mk(A_TIER, 32'h1));
        exp_q.push_back(mk(A_TCR, tcr | 32'h1));
        if (!stop_c0) begin
            for (int k = 1; k <= n; k++) begin
                exp_q.push_back(mk(A_TISR, 32'h1));
                if (per && !(k == n && stop_last)) begin
                    c = c + p;
                    exp_q.push_back(mk(A_TCMP0, c[31:0]));
                    exp_q.push_back(mk(A_TCMP1, c[63:32]));
                end
            end
        end
        exp_q.push_back(mk(A_TCR, tcr));
        exp_q.push_back(mk(A_TIER, 32'h0));
    endtask

    task automatic run_seq(input string name, input logic [63:0] t, input logic [63:0] p, input bit per,
                           input bit de, input logic [3:0] dv, input int n,
                           input bit stop_last, input bit stop_c0);
        int  base, dbase, tb, cyc, nexp;
        wr_t g;
        tdr   = t;
        base  = got_q.size();
        dbase = done_cnt;
        build_exp(t, p, per, de, dv, n, stop_last, stop_c0);
        do_start(p, per, de, dv);
        chk({name, " cfg_err"}, 64'(cfg_seen), 64'h0);
        if (stop_c0) begin
            cyc = 0;
            while (!(tim_psel && tim_penable && tim_pwrite && tim_paddr == A_TCMP0) && cyc < 300) begin
                @(negedge sys_clk); cyc++;
            end
            if (cyc >= 300) chk({name, " wait_c0 timeout"}, 64'h0, 64'h1);
            stop = 1'b1;
            tick(1);
            stop = 1'b0;
        end else begin
            wait_writes(base + 4, name);
            tick(10);
            for (int k = 1; k <= n; k++) begin
                tb = tisr_cnt;
                tim_int = 1'b1;
                if (k == n && stop_last) stop = 1'b1;
                tick(1);
                stop = 1'b0;
                wait_tisr(tb, name);
                tim_int = 1'b0;
                if (per) tick(25);
            end
            if (per && !stop_last) begin
                stop = 1'b1;
                tick(1);
                stop = 1'b0;
            end
        end
        wait_idle(name);
        tick(2);
        chk({name, " nwr"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            g = '0;
            if (base + i < got_q.size()) g = got_q[base + i];
            chk($sformatf("%s wr%0d", name, i), 64'(g), 64'(exp_q[i]));
        end
        nexp = stop_c0 ? 0 : n;
        chk({name, " done"}, 64'(done_cnt - dbase), 64'(nexp));
        chk({name, " expire_cnt"}, 64'(expire_cnt), 64'(nexp));
        chk({name, " busy"}, 64'(busy), 64'h0);
    endtask

    initial begin
        logic [63:0] rt, rp;
        bit          rper;
        int          rn, cyc;

        tick(3);
        sys_rst_n = 1'b1;
        tick(2);
        chk("rst psel", 64'(tim_psel), 64'h0);
        chk("rst penable", 64'(tim_penable), 64'h0);
        chk("rst busy", 64'(busy), 64'h0);
        chk("rst done", 64'(done), 64'h0);
        chk("rst expire_cnt", 64'(expire_cnt), 64'h0);
        chk("rst cfg_err", 64'(cfg_err), 64'h0);
        chk("rst bus_err", 64'(bus_err), 64'h0);

        run_seq("oneshot", 64'h0, 64'd100, 1'b0, 1'b0, 4'd0, 1, 1'b0, 1'b0);
        run_seq("carry", 64'h0000_0000_FFFF_FFF0, 64'h20, 1'b0, 1'b1, 4'd12, 1, 1'b0, 1'b0);
        run_seq("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 1'b0, 4'd3, 1, 1'b0, 1'b0);
        run_seq("periodic", 64'h0, 64'd50, 1'b1, 1'b0, 4'd0, 3, 1'b0, 1'b0);
        run_seq("bigper", 64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0005, 1'b1, 1'b1, 4'd5, 2, 1'b0, 1'b0);

        fixed_delay = 3;
        run_seq("stop_c0", 64'h0, 64'd77, 1'b1, 1'b0, 4'd1, 0, 1'b0, 1'b1);
        fixed_delay = -1;
        run_seq("int_stop", 64'h0, 64'd40, 1'b1, 1'b0, 4'd2, 2, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rt   = {$urandom, $urandom};
            rp   = {$urandom, $urandom};
            if (rp == 64'h0) rp = 64'h1;
            rper = 1'($urandom_range(0, 1));
            rn   = rper ? int'($urandom_range(1, 3)) : 1;
            run_seq($sformatf("rand%0d", r), rt, rp, rper, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), rn, 1'($urandom_range(0, 1)) & rper, 1'b0);
        end

        // Timeout, rejected start, then recovery
        stall = 1'b1;
        tdr   = 64'h0;
        do_start(64'd10, 1'b0, 1'b0, 4'd0);
        cyc = 0;
        while (!(tim_psel && tim_penable) && cyc < 50) begin @(negedge sys_clk); cyc++; end
        while (tim_psel && cyc < 100) begin @(negedge sys_clk); cyc++; end
        if (cyc >= 100) chk("tmo wait timeout", 64'(tim_psel), 64'h0);
        tick(2);
        chk("tmo access cycles", 64'(access_cycles), 64'd16);
        chk("tmo bus_err", 64'(bus_err), 64'h1);
        chk("tmo busy", 64'(busy), 64'h0);
        chk("tmo psel", 64'(tim_psel), 64'h0);
        stall = 1'b0;
        do_start(64'h0, 1'b0, 1'b0, 4'd0);
        chk("zero period cfg_err", 64'(cfg_seen), 64'h1);
        chk("zero period busy", 64'(busy), 64'h0);
        chk("zero period bus_err kept", 64'(bus_err), 64'h1);
        tick(1);
        chk("cfg_err pulse", 64'(cfg_err), 64'h0);
        run_seq("recover", 64'h0, 64'd10, 1'b0, 1'b0, 4'd0, 1, 1'b0, 1'b0);
        chk("recover bus_err", 64'(bus_err), 64'h0);

        // Reset during a transfer drops the bus immediately
        do_start(64'd5, 1'b0, 1'b0, 4'd0);
        cyc = 0;
        while (!tim_psel && cyc < 50) begin @(negedge sys_clk); cyc++; end
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async rst psel", 64'(tim_psel), 64'h0);
        chk("async rst penable", 64'(tim_penable), 64'h0);
        chk("async rst busy", 64'(busy), 64'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick(3);
        chk("post rst psel", 64'(tim_psel), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
